// File: rtl/input_conditioner.sv
// Push-button front end for the game FSM: synchronizes and debounces three buttons,
// then turns them into single-cycle command pulses, with auto-repeat on left/right.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 7500000
) (
    input  logic clk,
    input  logic rst,
    input  logic left_raw,
    input  logic right_raw,
    input  logic put_raw,
    input  logic enable,
    output logic left,
    output logic right,
    output logic put,
    output logic any_held
);

    localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_P  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int CW     = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RD_LOAD  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RP_LOAD  = CW'(REPEAT_PERIOD);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

    // Button index: 0 = left, 1 = right, 2 = put.
    logic [2:0]    raw;
    logic [2:0]    sync1, sync2, deb, deb_next, rise, fall;
    logic [CW-1:0] db_cnt [3];
    logic [CW-1:0] db_cnt_next [3];

    rpt_state_t    state [2];
    rpt_state_t    state_next [2];
    logic [CW-1:0] rpt_cnt [2];
    logic [CW-1:0] rpt_cnt_next [2];
    logic [1:0]    fire;
    logic          both_held;

    assign raw = {put_raw, right_raw, left_raw};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
            deb_next[i]    = deb[i];
            db_cnt_next[i] = '0;
            rise[i]        = 1'b0;
            fall[i]        = 1'b0;
            if (sync2[i] != deb[i]) begin
                if (db_cnt[i] == DEB_LAST) begin
                    deb_next[i] = sync2[i];
                    rise[i]     = sync2[i];
                    fall[i]     = ~sync2[i];
                end else begin
                    db_cnt_next[i] = db_cnt[i] + ONE;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_next[i]   = state[i];
            rpt_cnt_next[i] = rpt_cnt[i];
            fire[i]         = 1'b0;
            case (state[i])
                IDLE: begin
                    if (rise[i]) begin
                        state_next[i]   = DELAY;
                        rpt_cnt_next[i] = RD_LOAD;
                        fire[i]         = 1'b1;
                    end
                end
                DELAY, REPEAT: begin
                    if (fall[i]) begin
                        state_next[i]   = IDLE;
                        rpt_cnt_next[i] = '0;
                    end else if (rpt_cnt[i] == ONE) begin
                        state_next[i]   = REPEAT;
                        rpt_cnt_next[i] = RP_LOAD;
                        fire[i]         = 1'b1;
                    end else begin
                        rpt_cnt_next[i] = rpt_cnt[i] - ONE;
                    end
                end
                default: begin
                    state_next[i]   = IDLE;
                    rpt_cnt_next[i] = '0;
                end
            endcase
        end
    end

    // Chord suppression looks at the levels as they stand after this edge.
    assign both_held = deb_next[0] & deb_next[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            deb      <= '0;
            left     <= 1'b0;
            right    <= 1'b0;
            put      <= 1'b0;
            any_held <= 1'b0;
            // NOTE: these counter arrays are control state, so they are reset element by element.
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
            for (int i = 0; i < 2; i++) begin
                state[i]   <= IDLE;
                rpt_cnt[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values.
            sync1    <= raw;
            sync2    <= sync1;
            deb      <= deb_next;
            left     <= enable & fire[0] & ~both_held;
            right    <= enable & fire[1] & ~both_held;
            put      <= enable & rise[2];
            any_held <= |deb_next;
            for (int i = 0; i < 3; i++) db_cnt[i] <= db_cnt_next[i];
            for (int i = 0; i < 2; i++) begin
                state[i]   <= state_next[i];
                rpt_cnt[i] <= rpt_cnt_next[i];
            end
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Cycle c is the c-th rising edge after reset release; outputs are sampled 1 time unit after it.
module tb_input_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic left_raw = 1'b0;
    logic right_raw = 1'b0;
    logic put_raw = 1'b0;
    logic enable = 1'b1;
    logic left, right, put, any_held;

    int n_tests = 0;
    int n_fail  = 0;

    input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .left_raw (left_raw),
        .right_raw(right_raw),
        .put_raw  (put_raw),
        .enable   (enable),
        .left     (left),
        .right    (right),
        .put      (put),
        .any_held (any_held)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic in_q(input int q[$], input int c);
        foreach (q[k]) if (q[k] == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        left_raw = 1'b0;
        right_raw = 1'b0;
        put_raw = 1'b0;
        enable = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Buttons pressed through reset: nothing during reset, then treated as a fresh press.
    task automatic test_reset();
        int ep[$];
        logic [3:0] exp;
        ep = '{6};
        rst = 1'b1;
        left_raw = 1'b1;
        right_raw = 1'b1;
        put_raw = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++;
            if ({left, right, put, any_held} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d got %b expected 0000", c, {left, right, put, any_held});
            end
        end
        rst = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            exp = {1'b0, 1'b0, in_q(ep, c), 1'(c >= 6)};
            n_tests++;
            if ({left, right, put, any_held} !== exp) begin
                n_fail++;
                $display("FAIL reset_release cycle %0d got %b expected %b", c, {left, right, put, any_held}, exp);
            end
        end
    endtask

    task automatic test_put();
        int ep[$];
        logic [3:0] exp;
        ep = '{6};
        do_reset();
        put_raw = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            exp = {1'b0, 1'b0, in_q(ep, c), 1'(c >= 6)};
            n_tests++;
            if ({left, right, put, any_held} !== exp) begin
                n_fail++;
                $display("FAIL put cycle %0d got %b expected %b", c, {left, right, put, any_held}, exp);
            end
        end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            left_raw = (c <= 3);
            tick();
            n_tests++;
            if ({left, right, put, any_held} !== 4'b0000) begin
                n_fail++;
                $display("FAIL bounce cycle %0d got %b expected 0000", c, {left, right, put, any_held});
            end
        end
        left_raw = 1'b0;
    endtask

    task automatic test_right_repeat();
        int er[$];
        logic [3:0] exp;
        er = '{6, 16, 19, 22, 25, 28, 31, 34};
        do_reset();
        for (int c = 1; c <= 45; c++) begin
            right_raw = (c <= 30);
            tick();
            exp = {1'b0, in_q(er, c), 1'b0, 1'(c >= 6 && c < 36)};
            n_tests++;
            if ({left, right, put, any_held} !== exp) begin
                n_fail++;
                $display("FAIL right_repeat cycle %0d got %b expected %b", c, {left, right, put, any_held}, exp);
            end
        end
    endtask

    task automatic test_both_held();
        int el[$];
        logic [3:0] exp;
        el = '{6, 37, 40, 43, 46, 49};
        do_reset();
        for (int c = 1; c <= 55; c++) begin
            left_raw  = (c <= 45);
            right_raw = (c >= 10 && c <= 29);
            tick();
            exp = {in_q(el, c), 1'b0, 1'b0, 1'(c >= 6 && c < 51)};
            n_tests++;
            if ({left, right, put, any_held} !== exp) begin
                n_fail++;
                $display("FAIL both_held cycle %0d got %b expected %b", c, {left, right, put, any_held}, exp);
            end
        end
    endtask

    task automatic test_enable();
        int el[$];
        logic [3:0] exp;
        el = '{19, 22, 25};
        do_reset();
        for (int c = 1; c <= 25; c++) begin
            left_raw = 1'b1;
            enable   = (c >= 18);
            tick();
            exp = {in_q(el, c), 1'b0, 1'b0, 1'(c >= 6)};
            n_tests++;
            if ({left, right, put, any_held} !== exp) begin
                n_fail++;
                $display("FAIL enable cycle %0d got %b expected %b", c, {left, right, put, any_held}, exp);
            end
        end
        left_raw = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_reset_mid_repeat();
        int er[$];
        logic [3:0] exp;
        er = '{6, 19};
        do_reset();
        for (int c = 1; c <= 26; c++) begin
            right_raw = 1'b1;
            rst = (c == 12 || c == 13);
            if (c == 12) begin
                #1;
                n_tests++;
                if ({left, right, put, any_held} !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL reset_async got %b expected 0000", {left, right, put, any_held});
                end
            end
            tick();
            exp = {1'b0, in_q(er, c), 1'b0, 1'((c >= 6 && c <= 11) || c >= 19)};
            n_tests++;
            if ({left, right, put, any_held} !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_repeat cycle %0d got %b expected %b", c, {left, right, put, any_held}, exp);
            end
        end
        right_raw = 1'b0;
    endtask

    initial begin
        test_reset();
        test_put();
        test_bounce();
        test_right_repeat();
        test_both_held();
        test_enable();
        test_reset_mid_repeat();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
